// File: rtl/alu_result_stage_if.sv
// Opcode type shared with the ALU, plus the handshake bundle between the ALU,
// the result stage and register-file write-back.
package alu_result_pkg;
    typedef enum logic [3:0] {
        ALU_OP_AND = 4'd0,
        ALU_OP_OR  = 4'd1,
        ALU_OP_XOR = 4'd2,
        ALU_OP_NOT = 4'd3,
        ALU_OP_ADD = 4'd4,
        ALU_OP_SUB = 4'd5,
        ALU_OP_SHL = 4'd6,
        ALU_OP_SHR = 4'd7,
        ALU_OP_CPR = 4'd8
    } enum_alu_opcode_t;
endpackage

interface alu_result_stage_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DEST_WIDTH = 3
);
    import alu_result_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    enum_alu_opcode_t      in_opcode;
    logic [DATA_WIDTH-1:0] in_result;
    logic [2:0]            in_flag;
    logic [DEST_WIDTH-1:0] in_dest;

    logic                  wb_valid;
    logic                  wb_ready;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [DEST_WIDTH-1:0] wb_dest;

    // master: the ALU side producing results and the register file consuming them
    modport master (
        output in_valid, in_opcode, in_result, in_flag, in_dest, wb_ready,
        input  in_ready, wb_valid, wb_data, wb_dest
    );

    modport slave (
        input  in_valid, in_opcode, in_result, in_flag, in_dest, wb_ready,
        output in_ready, wb_valid, wb_data, wb_dest
    );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry write-back FIFO for data results and a persistent
// condition-flag register fed by compare operations, with jump evaluation.
module alu_result_stage
    import alu_result_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEST_WIDTH = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_result_stage_if.slave bus,
    input  logic       flush,
    input  logic [2:0] cond_sel,
    output logic [2:0] flags_q,
    output logic       flag_valid,
    output logic       jump_take,
    output logic       flag_err
);

    logic [1:0]            count_reg, count_next;
    logic [DATA_WIDTH-1:0] data_reg [2];
    logic [DATA_WIDTH-1:0] data_next [2];
    logic [DEST_WIDTH-1:0] dest_reg [2];
    logic [DEST_WIDTH-1:0] dest_next [2];

    logic [2:0] flags_reg;
    logic       flag_valid_reg;
    logic       flag_err_reg;

    logic accept;
    logic is_cpr;
    logic push;
    logic pop;
    logic flag_legal;

    assign bus.in_ready = (count_reg != 2'd2);
    assign bus.wb_valid = (count_reg != 2'd0);
    assign bus.wb_data  = data_reg[0];
    assign bus.wb_dest  = dest_reg[0];

    assign accept     = bus.in_valid && bus.in_ready;
    assign is_cpr     = (bus.in_opcode == ALU_OP_CPR);
    assign push       = accept && !is_cpr;
    assign pop        = bus.wb_valid && bus.wb_ready;
    assign flag_legal = (bus.in_flag == 3'b100) || (bus.in_flag == 3'b010) ||
                        (bus.in_flag == 3'b001);

    // Entry 0 is always the head; entry 1 shifts down when the head leaves.
    always_comb begin
        count_next = count_reg;
        for (int i = 0; i < 2; i++) begin
            data_next[i] = data_reg[i];
            dest_next[i] = dest_reg[i];
        end
        if (flush) begin
            count_next = 2'd0;
        end else if (push && pop) begin
            // only reachable with count 1: the new entry replaces the head
            data_next[0] = bus.in_result;
            dest_next[0] = bus.in_dest;
        end else if (pop) begin
            count_next = count_reg - 2'd1;
            if (count_reg == 2'd2) begin
                data_next[0] = data_reg[1];
                dest_next[0] = dest_reg[1];
            end
        end else if (push) begin
            count_next = count_reg + 2'd1;
            if (count_reg == 2'd0) begin
                data_next[0] = bus.in_result;
                dest_next[0] = bus.in_dest;
            end else begin
                data_next[1] = bus.in_result;
                dest_next[1] = bus.in_dest;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                data_reg[i] <= '0;
                dest_reg[i] <= '0;
            end
        end else begin
            count_reg <= count_next;
            for (int i = 0; i < 2; i++) begin
                data_reg[i] <= data_next[i];
                dest_reg[i] <= dest_next[i];
            end
        end
    end

    // Flags are architectural state: a flush of the result buffer leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg      <= 3'b000;
            flag_valid_reg <= 1'b0;
            flag_err_reg   <= 1'b0;
        end else begin
            flag_err_reg <= accept && is_cpr && !flag_legal;
            if (accept && is_cpr && flag_legal) begin
                flags_reg      <= bus.in_flag;
                flag_valid_reg <= 1'b1;
            end
        end
    end

    assign flags_q    = flags_reg;
    assign flag_valid = flag_valid_reg;
    assign flag_err   = flag_err_reg;

    always_comb begin
        jump_take = 1'b0;
        case (cond_sel)
            3'b000:  jump_take = 1'b1;
            3'b001:  jump_take = flags_reg[2];
            3'b010:  jump_take = flags_reg[1];
            3'b011:  jump_take = flags_reg[0];
            3'b100:  jump_take = flags_reg[2] | flags_reg[1];
            3'b101:  jump_take = flags_reg[2] | flags_reg[0];
            3'b110:  jump_take = ~flags_reg[2];
            default: jump_take = 1'b0;
        endcase
        if (!flag_valid_reg && (cond_sel != 3'b000) && (cond_sel != 3'b111))
            jump_take = 1'b0;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream stage of the ALU logic unit. It captures the unit's data result and 3-bit compare flag under a valid/ready handshake.
- Data results go into a 2-entry buffer and are presented to register-file write-back.
- Compare (ALU_OP_CPR) outcomes update a persistent condition-flag register. The flag register drives conditional-jump evaluation for the control unit.

Parameters:
- DATA_WIDTH, 16, result/write-back data width. Matches CPU_package DATA_WIDTH.
- DEST_WIDTH, 3, destination register address width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  ALU result valid this cycle.
- in_ready  output  1  stage can accept. High iff buffer count < 2.
- in_opcode  input  enum_alu_opcode_t  opcode that produced the result.
- in_result  input  DATA_WIDTH  ALU logic_out.
- in_flag  input  3  ALU compare flag: 100 = EQ, 010 = GT, 001 = LT.
- in_dest  input  DEST_WIDTH  destination register.
- wb_valid  output  1  head entry valid.
- wb_ready  input  1  register file accepts head.
- wb_data  output  DATA_WIDTH  head result.
- wb_dest  output  DEST_WIDTH  head destination.
- flush  input  1  synchronous buffer clear.
- cond_sel  input  3  jump condition select.
- flags_q  output  3  current flag register.
- flag_valid  output  1  at least one legal compare captured since reset.
- jump_take  output  1  evaluated jump condition (combinational from flags_q, flag_valid, cond_sel).
- flag_err  output  1  one-cycle pulse: illegal compare flag seen.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count = 0; wb_valid = 0; wb_data = 0; wb_dest = 0.
  - flags_q = 000; flag_valid = 0; flag_err = 0.
  - in_ready = 1 once reset is released.
- Accept:
  - A transfer happens on a rising edge when in_valid && in_ready.
  - Non-CPR opcodes push {in_result, in_dest} at the tail.
  - CPR opcodes do not push. They update the flag register only (see below).
- Pop: on a rising edge when wb_valid && wb_ready, the head is removed and the second entry, if any, becomes head.
- Buffer: 2 entries, FIFO order. wb_* reflect the head. wb_data and wb_dest hold their last value when empty.
- Latency: a result accepted at edge N appears on wb_valid/wb_data after edge N (one cycle).
- Simultaneous push and pop:
  - count = 1: count stays 1; new entry becomes head after the edge.
  - count = 2: in_ready = 0, so only the pop occurs.
  - count = 0: push only. There is no same-cycle bypass.
- in_ready depends only on count, never on wb_ready. There is no combinational path from wb_ready to in_ready.
- Flag register:
  - Accepted CPR with one-hot in_flag (100, 010, 001): flags_q <= in_flag and flag_valid <= 1 at that edge.
  - Accepted CPR with non-one-hot in_flag: flags_q unchanged, flag_err = 1 for exactly one cycle.
  - flag_err is 0 in all other cycles.
- flush:
  - On a rising edge with flush = 1, count = 0 and wb_valid = 0.
  - flush has priority over push and pop in that cycle; any push or pop that cycle is discarded.
  - flags_q and flag_valid are unaffected.
- Jump evaluation, cond_sel encoding:
  - 000 always.
  - 001 EQ = flags_q[2].
  - 010 GT = flags_q[1].
  - 011 LT = flags_q[0].
  - 100 GE = EQ | GT.
  - 101 LE = EQ | LT.
  - 110 NE = ~EQ.
  - 111 never.
- Conditions 001–110 are forced to 0 while flag_valid = 0.
- Reset asserted mid-transfer: all state is cleared immediately. Buffered entries are lost and nothing is written back.
- Unknown or unused opcode values are treated as data results and pushed.

Test Plan:
- Reset release; AND result 0x00F0, dest 3, wb_ready = 1 -> wb_valid high one cycle later with wb_data = 0x00F0, wb_dest = 3; count returns to 0.
- wb_ready = 0; push OR 0x1234 then XOR 0x5555 -> in_ready drops to 0 after the second push. A third in_valid is not accepted. Raising wb_ready pops 0x1234 then 0x5555 in order.
- count = 1, push and pop in the same cycle -> count stays 1 and the new data is at the head next cycle. No loss, no duplication.
- CPR with in_flag = 010 -> flags_q = 010, flag_valid = 1, no wb_valid. jump_take is 1 for cond_sel 010, 100, 110 and 0 for 001, 011, 101.
- CPR with in_flag = 011 -> flag_err pulses for one cycle, flags_q retains its previous value. Before any legal CPR, cond_sel 001 gives jump_take = 0 and cond_sel 000 gives 1.
- Buffer full with flags_q = 100; assert flush together with a pop -> count = 0, wb_valid = 0, flags_q stays 100. Assert rst_n low mid-stream -> all outputs return to reset values asynchronously.
